// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman result path: default score
// geometry, the queued result entry type and a ceil-log2 helper.
package sw_pkg;

    localparam int SW_SCORE_WIDTH = 12;
    localparam int SW_ZERO        = 2**(SW_SCORE_WIDTH-1);
    localparam int SW_ID_WIDTH    = 16;

    // One finished alignment as seen by the host side.
    typedef struct packed {
        logic [SW_SCORE_WIDTH-1:0] score;
        logic                      lane;
        logic [SW_ID_WIDTH-1:0]    id;
    } sw_result_t;

    // Ceil-log2, minimum 1 so pointer widths never collapse to zero.
    function automatic int log2b(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_result_fifo.sv
// Dual-write / single-read FIFO. Up to two entries enter per cycle, packed
// into consecutive slots (port 0 first); one entry leaves per cycle. Space
// freed by a same-cycle pop is usable by the writes.
module sw_result_fifo
    import sw_pkg::*;
#(
    parameter int WIDTH = 29,
    parameter int DEPTH = 8,
    localparam int AW   = log2b(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr0,
    input  logic             wr1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic [1:0]       acc_cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr, wptr1;
    logic [CW-1:0]    space;
    logic             pop, acc0, acc1;

    assign valid = (count != '0);
    assign head  = mem[rptr];
    assign pop   = valid && ready;
    assign wptr1 = wptr + 1'b1;

    // Admission: port 0 has priority; port 1 needs a second free slot only
    // when port 0 also took one.
    always_comb begin
        space   = CW'(DEPTH) - count + CW'(pop);
        acc0    = wr0 && (space != '0);
        acc1    = wr1 && (acc0 ? (space >= CW'(2)) : (space != '0));
        acc_cnt = {1'b0, acc0} + {1'b0, acc1};
    end

    // Storage write; accepted entries are compacted starting at wptr.
    always_ff @(posedge clk) begin
        if (acc0 || acc1) mem[wptr] <= acc0 ? data0 : data1;
        if (acc0 && acc1) mem[wptr1] <= data1;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(acc_cnt);
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(acc_cnt) - CW'(pop);
        end
    end

endmodule

// File: rtl/sw_result_collector.sv
// Captures each finished score from the two scoring-array lanes on the
// rising edge of its valid level, removes the bias (clamping at zero), tags
// it with lane and sequence ID and queues it for the host side.
module sw_result_collector
    import sw_pkg::*;
#(
    parameter int SCORE_WIDTH = SW_SCORE_WIDTH,
    parameter int ZERO        = 2**(SCORE_WIDTH-1),
    parameter int DEPTH       = 8,
    parameter int ID_WIDTH    = SW_ID_WIDTH,
    localparam int CW         = log2b(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld0,
    input  logic                   vld1,
    input  logic [SCORE_WIDTH-1:0] result0,
    input  logic [SCORE_WIDTH-1:0] result1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SCORE_WIDTH-1:0] out_score,
    output logic                   out_lane,
    output logic [ID_WIDTH-1:0]    out_id,
    output logic [CW-1:0]          count,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    localparam int EW = SCORE_WIDTH + 1 + ID_WIDTH;
    localparam logic [SCORE_WIDTH-1:0] ZERO_V = SCORE_WIDTH'(ZERO);

    logic                   vld0_q, vld1_q, req0, req1, drop;
    logic [SCORE_WIDTH-1:0] score0, score1;
    logic [ID_WIDTH-1:0]    id_ctr, id1;
    logic [EW-1:0]          entry0, entry1, head;
    logic [1:0]             acc_cnt;

    assign req0 = vld0 && !vld0_q;
    assign req1 = vld1 && !vld1_q;

    // Unbias with clamp, and ID tagging: lane 1 follows lane 0 when both fire.
    // If lane 0 requests but is dropped, lane 1 is dropped too, so id1 only
    // depends on the request.
    always_comb begin
        score0 = (result0 >= ZERO_V) ? result0 - ZERO_V : '0;
        score1 = (result1 >= ZERO_V) ? result1 - ZERO_V : '0;
        id1    = id_ctr + ID_WIDTH'(req0);
        entry0 = {score0, 1'b0, id_ctr};
        entry1 = {score1, 1'b1, id1};
        drop   = (({1'b0, req0} + {1'b0, req1}) != acc_cnt);
    end

    sw_result_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr0     (req0),
        .wr1     (req1),
        .data0   (entry0),
        .data1   (entry1),
        .ready   (out_ready),
        .head    (head),
        .valid   (out_valid),
        .count   (count),
        .acc_cnt (acc_cnt)
    );

    assign {out_score, out_lane, out_id} = head;

    // Edge-detect history, ID counter (dropped captures take no ID) and the
    // sticky overflow flag where a new drop beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld0_q   <= 1'b0;
            vld1_q   <= 1'b0;
            id_ctr   <= '0;
            overflow <= 1'b0;
        end else begin
            vld0_q <= vld0;
            vld1_q <= vld1;
            id_ctr <= id_ctr + ID_WIDTH'(acc_cnt);
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sw_result_collector.sv
// Directed bench for sw_result_collector: a table of single-lane captures
// plus hand-written sequences for dual capture, full FIFO and async reset.
module tb_sw_result_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld0 = 1'b0, vld1 = 1'b0;
    logic [11:0] result0 = '0, result1 = '0;
    logic        out_valid, out_lane, overflow;
    logic        out_ready = 1'b0, clr_ovf = 1'b0;
    logic [11:0] out_score;
    logic [15:0] out_id;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;
    int eid;

    typedef struct {
        logic        lane;
        logic [11:0] result;
        logic [11:0] exp_score;
    } vec_t;
    vec_t vecs [6];

    sw_result_collector dut (
        .clk(clk), .rst(rst), .vld0(vld0), .vld1(vld1),
        .result0(result0), .result1(result1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_score(out_score), .out_lane(out_lane), .out_id(out_id),
        .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input int s, input int l, input int id);
        chk({name, ".valid"}, int'(out_valid), 1);
        chk({name, ".score"}, int'(out_score), s);
        chk({name, ".lane"},  int'(out_lane), l);
        chk({name, ".id"},    int'(out_id), id);
    endtask

    initial begin
        vecs[0] = '{1'b1, 12'h7F0, 12'd0};
        vecs[1] = '{1'b0, 12'h800, 12'd0};
        vecs[2] = '{1'b1, 12'hFFF, 12'h7FF};
        vecs[3] = '{1'b0, 12'h801, 12'd1};
        vecs[4] = '{1'b1, 12'h7FF, 12'd0};
        vecs[5] = '{1'b0, 12'h123, 12'd0};

        // Reset state
        #12;
        chk("rst.valid", int'(out_valid), 0);
        chk("rst.count", int'(count), 0);
        chk("rst.ovf",   int'(overflow), 0);
        tick;
        rst = 1'b0;
        tick;

        // Single capture, level held 5 cycles
        result0 = 12'h80A; vld0 = 1'b1;
        tick;
        chk_head("single", 10, 0, 0);
        chk("single.count", int'(count), 1);
        repeat (4) tick;
        chk("single.held_count", int'(count), 1);
        vld0 = 1'b0; out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("single.drained", int'(count), 0);
        eid = 1;

        // Table of single-lane captures incl. clamp and bias boundaries
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].lane) begin result1 = vecs[i].result; vld1 = 1'b1; end
            else              begin result0 = vecs[i].result; vld0 = 1'b1; end
            tick;
            vld0 = 1'b0; vld1 = 1'b0;
            chk_head($sformatf("vec%0d", i), int'(vecs[i].exp_score), int'(vecs[i].lane), eid);
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
            chk($sformatf("vec%0d.count", i), int'(count), 0);
            eid++;
        end

        // Simultaneous lanes
        result0 = 12'h805; result1 = 12'h807; vld0 = 1'b1; vld1 = 1'b1;
        tick;
        vld0 = 1'b0; vld1 = 1'b0;
        chk("dual.count", int'(count), 2);
        chk_head("dual0", 5, 0, eid);
        out_ready = 1'b1;
        tick;
        chk_head("dual1", 7, 1, eid + 1);
        chk("dual.count1", int'(count), 1);
        tick;
        out_ready = 1'b0;
        chk("dual.count0", int'(count), 0);
        eid += 2;

        // Fill to 7, then both lanes rise: lane 1 dropped
        for (int i = 0; i < 7; i++) begin
            result0 = 12'(12'h800 + i); vld0 = 1'b1;
            tick;
            vld0 = 1'b0;
            tick;
        end
        chk("fill.count", int'(count), 7);
        result0 = 12'h820; result1 = 12'h821; vld0 = 1'b1; vld1 = 1'b1;
        tick;
        chk("full2.count", int'(count), 8);
        chk("full2.ovf", int'(overflow), 1);
        vld0 = 1'b0; vld1 = 1'b0; clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        chk("clr.ovf", int'(overflow), 0);

        // Drop and clear in the same cycle: set wins
        vld0 = 1'b1; clr_ovf = 1'b1;
        tick;
        chk("setwins.ovf", int'(overflow), 1);
        tick;
        clr_ovf = 1'b0;
        chk("setwins.clr", int'(overflow), 0);
        vld0 = 1'b0;

        // Full push/pop: count stays 8, no overflow; lane 1 gets eid+8
        result1 = 12'h80F; vld1 = 1'b1; out_ready = 1'b1;
        tick;
        vld1 = 1'b0;
        chk("pp.count", int'(count), 8);
        chk("pp.ovf", int'(overflow), 0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain%0d.id", j), int'(out_id), eid + 1 + j);
            if (j == 7) begin
                chk("drain.last_score", int'(out_score), 15);
                chk("drain.last_lane", int'(out_lane), 1);
            end
            tick;
        end
        out_ready = 1'b0;
        chk("drain.count", int'(count), 0);

        // Async reset mid-stream with 3 queued entries
        for (int i = 0; i < 3; i++) begin
            result0 = 12'h830; vld0 = 1'b1;
            tick;
            vld0 = 1'b0;
            tick;
        end
        chk("pre_rst.count", int'(count), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", int'(out_valid), 0);
        chk("arst.count", int'(count), 0);
        chk("arst.ovf",   int'(overflow), 0);
        tick;
        rst = 1'b0;
        tick;
        result0 = 12'h810; vld0 = 1'b1;
        tick;
        vld0 = 1'b0;
        chk_head("post_rst", 16, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
